lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_rmw_if.sv | 31 +++
 rtl/lsu_rmw.sv | 141 ++++++++++++++
 tb/tb_lsu_rmw.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rmw_if.sv
// Core request/response and data-memory bundle for lsu_rmw.
// slave is the LSU view; master is the core/memory view.
interface lsu_rmw_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/lsu_rmw.sv
// RV32I load/store unit with read-modify-write for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module lsu_rmw (
  input  logic      CLK,
  input  logic      RST,
  lsu_rmw_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, MERGE, WRITE, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        code_ok;
  logic        mis;

  function automatic logic [31:0] ext(
    input logic [2:0]  f,
    input logic [31:0] d
  );
    case (f)
      3'd0:    ext = {{24{d[7]}}, d[7:0]};
      3'd1:    ext = {{16{d[15]}}, d[15:0]};
      3'd4:    ext = {24'h0, d[7:0]};
      3'd5:    ext = {16'h0, d[15:0]};
      default: ext = d;
    endcase
  endfunction

  always_comb begin
    if (bus.req_we)
      code_ok = bus.req_funct3 <= 3'd2;
    else
      code_ok = bus.req_funct3 != 3'd3 &&
                bus.req_funct3 <= 3'd5;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // H/HU/SH share funct3[1:0]=01, W/SW use 10
  assign mis =
    (bus.req_funct3[1:0] == 2'b01 &&
     bus.req_addr[0]) ||
    (bus.req_funct3[1:0] == 2'b10 &&
     bus.req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    f3_d          = f3_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    merge_d       = merge_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.req_ready = 1'b0;
    bus.mem_A     = 32'h0;
    bus.mem_WD    = 32'h0;
    bus.mem_WE    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (!code_ok || mis) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!bus.req_we)
            state_d = LOAD;
          else if (bus.req_funct3 == 3'd2)
            state_d = WRITE;
          else
            state_d = MERGE;
        end
      end
      LOAD: begin
        bus.mem_A = addr_q;
        rdata_d   = ext(f3_q, bus.mem_RD);
        state_d   = RESP;
      end
      MERGE: begin
        bus.mem_A = addr_q;
        if (f3_q[0])
          merge_d = {bus.mem_RD[31:16], wdata_q[15:0]};
        else
          merge_d = {bus.mem_RD[31:8], wdata_q[7:0]};
        state_d = WRITE;
      end
      WRITE: begin
        bus.mem_A  = addr_q;
        bus.mem_WE = !RST;
        bus.mem_WD = (f3_q == 3'd2) ? wdata_q : merge_q;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  logic unused;
  assign unused = we_q;
endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a byte-addressed memory model.
// Build with +define+LSU_MISALIGN_TRAP_EN to check the trap build.
module tb_lsu_rmw;
  logic CLK;
  logic RST;
  lsu_rmw_if bus();

  lsu_rmw dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  logic [7:0]  mem [0:65535];
  logic        pl_we;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;

  function automatic logic [31:0] rdw(input logic [31:0] a);
    logic [15:0] i;
    i = a[15:0];
    rdw = {mem[i + 16'd3], mem[i + 16'd2],
           mem[i + 16'd1], mem[i]};
  endfunction

  assign bus.mem_RD = rdw(bus.mem_A);

  always @(posedge CLK) begin
    logic [15:0] i;
    if (bus.mem_WE) begin
      i = bus.mem_A[15:0];
      mem[i]         <= bus.mem_WD[7:0];
      mem[i + 16'd1] <= bus.mem_WD[15:8];
      mem[i + 16'd2] <= bus.mem_WD[23:16];
      mem[i + 16'd3] <= bus.mem_WD[31:24];
      we_cnt <= we_cnt + 1;
    end else if (pl_we) begin
      i = pl_addr[15:0];
      mem[i]         <= pl_data[7:0];
      mem[i + 16'd1] <= pl_data[15:8];
      mem[i + 16'd2] <= pl_data[23:16];
      mem[i + 16'd3] <= pl_data[31:24];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic preload(
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(negedge CLK);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge CLK);
    #1 pl_we = 1'b0;
  endtask

  task automatic do_req(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output int          lat,
    output logic [31:0] rd,
    output logic        err
  );
    logic rdy;
    rdy = 1'b0;
    for (int k = 0; k < 6 && !rdy; k++) begin
      @(negedge CLK);
      rdy = bus.req_ready;
    end
    chk("ready_wait", {31'h0, rdy}, 32'h1);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    rd  = 32'hx;
    err = 1'bx;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (bus.rsp_valid) begin
        lat = i;
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
      end else begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  int          wc;

  initial begin
    RST = 1'b1;
    pl_we = 1'b0;
    pl_addr = 32'h0;
    pl_data = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_we", {31'h0, bus.mem_WE}, 32'h0);
    chk("rst_addr", bus.mem_A, 32'h0);

    preload(32'h2000, 32'h000000F0);
    preload(32'h2004, 32'h55667788);
    preload(32'h200C, 32'h11223344);
    preload(32'h2010, 32'hAAAAAAAA);

    do_req(1'b0, 3'd0, 32'h2000, 32'h0, lat, rd, err);
    chk("lb_data", rd, 32'hFFFFFFF0);
    chk("lb_lat", lat, 2);
    chk("lb_err", {31'h0, err}, 32'h0);

    do_req(1'b0, 3'd4, 32'h2000, 32'h0, lat, rd, err);
    chk("lbu_data", rd, 32'h000000F0);
    chk("lbu_lat", lat, 2);

    do_req(1'b1, 3'd0, 32'h200C, 32'hAB, lat, rd, err);
    chk("sb_lat", lat, 3);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_err", {31'h0, err}, 32'h0);
    chk("sb_mem", rdw(32'h200C), 32'h112233AB);

    do_req(1'b1, 3'd1, 32'h2010, 32'h0000BEEF, lat, rd, err);
    chk("sh_lat", lat, 3);
    chk("sh_mem", rdw(32'h2010), 32'hAAAABEEF);
    do_req(1'b0, 3'd1, 32'h2010, 32'h0, lat, rd, err);
    chk("lh_data", rd, 32'hFFFFBEEF);
    do_req(1'b0, 3'd5, 32'h2010, 32'h0, lat, rd, err);
    chk("lhu_data", rd, 32'h0000BEEF);

    do_req(1'b1, 3'd2, 32'h2020, 32'h12345678, lat, rd, err);
    chk("sw_lat", lat, 2);
    chk("sw_mem", rdw(32'h2020), 32'h12345678);
    do_req(1'b0, 3'd2, 32'h2020, 32'h0, lat, rd, err);
    chk("lw_data", rd, 32'h12345678);
    chk("lw_lat", lat, 2);

    wc = we_cnt;
    do_req(1'b0, 3'd3, 32'h2020, 32'h0, lat, rd, err);
    chk("bad_ld_err", {31'h0, err}, 32'h1);
    chk("bad_ld_rdata", rd, 32'h0);
    chk("bad_ld_lat", lat, 1);
    do_req(1'b1, 3'd4, 32'h2020, 32'hFFFFFFFF, lat, rd, err);
    chk("bad_st_err", {31'h0, err}, 32'h1);
    chk("bad_st_lat", lat, 1);
    chk("bad_st_mem", rdw(32'h2020), 32'h12345678);
    chk("bad_no_we", we_cnt, wc);

    do_req(1'b0, 3'd2, 32'h2001, 32'h0, lat, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_lat", lat, 1);
`else
    chk("mis_err", {31'h0, err}, 32'h0);
    chk("mis_rdata", rd, 32'h88000000);
    chk("mis_lat", lat, 2);
`endif

    preload(32'h2000, 32'h0000000A);
    @(negedge CLK);
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h2000;
    bus.req_wdata  = 32'hDEADBEEF;
    bus.req_valid  = 1'b1;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    chk("wr_we_hi", {31'h0, bus.mem_WE}, 32'h1);
    wc = we_cnt;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("wr_we_gated", {31'h0, bus.mem_WE}, 32'h0);
    @(posedge CLK);
    #1;
    chk("wr_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("wr_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    chk("wr_rel_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("wr_mem_kept", rdw(32'h2000), 32'h0000000A);
    chk("wr_no_we", we_cnt, wc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
